// File: rtl/disk_ctrl_pkg.sv
// rtl/disk_ctrl_pkg.sv - shared types, widths and round-robin search for the disk point arbiter
package disk_ctrl_pkg;

  localparam int COORD_W = 32;
  localparam int SEED_W  = 32;
  localparam int CNT_W   = 16;
  localparam int MAX_REQ = 16;
  localparam int IDX_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    RESEED,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  // First set bit of req[0..n-1] searching upward from ptr+1 with wrap-around.
  function automatic logic [IDX_W-1:0] rr_next(input logic [MAX_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr,
                                               input int                 n);
    logic [IDX_W-1:0] g;
    logic             found;
    int               idx;
    g     = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (k <= n && !found && req[IDX_W'(idx)]) begin
        g     = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant; pointer state lives in the parent
module rr_arbiter
  import disk_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req
);

  always_comb begin
    any_req   = |req;
    grant_idx = ID_W'(rr_next(MAX_REQ'(req), IDX_W'(ptr), NUM_REQ));
    grant     = any_req ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/disk_point_arbiter.sv
// rtl/disk_point_arbiter.sv - round-robin sharing of one disk_32bit point generator
module disk_point_arbiter
  import disk_ctrl_pkg::*;
#(
  parameter int  NUM_REQ        = 4,
  localparam int ID_W           = $clog2(NUM_REQ),
  parameter int  TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_reseed,
  input  logic [32*NUM_REQ-1:0] req_seed,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_x,
  output logic [31:0]           resp_y,
  output logic                  resp_err,
  output logic                  gen_pop,
  output logic                  gen_reseed,
  output logic [31:0]           gen_seed,
  input  logic [31:0]           gen_x,
  input  logic [31:0]           gen_y,
  input  logic                  gen_valid,
  output logic [15:0]           served_cnt,
  output logic                  err_timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0]  PTR_RESET    = ID_W'(NUM_REQ - 1);

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d, id_q, id_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic                 err_q, err_d, resp_valid_q, resp_valid_d;
  logic                 gen_pop_q, gen_pop_d, gen_reseed_q, gen_reseed_d;
  logic [SEED_W-1:0]    seed_q, seed_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d, served_q, served_d;
  logic                 err_timeout_q, err_timeout_d;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_idx;
  logic                 any_req;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    x_d           = x_q;
    y_d           = y_q;
    err_d         = err_q;
    resp_valid_d  = resp_valid_q;
    gen_pop_d     = 1'b0;
    gen_reseed_d  = 1'b0;
    seed_d        = seed_q;
    wait_cnt_d    = wait_cnt_q;
    served_d      = served_q;
    err_timeout_d = err_timeout_q;
    req_ready     = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready = grant;
          id_d      = grant_idx;
          if (req_reseed[grant_idx]) begin
            seed_d       = req_seed[SEED_W*int'(grant_idx) +: SEED_W];
            gen_reseed_d = 1'b1;
            state_d      = RESEED;
          end else begin
            gen_pop_d = 1'b1;
            state_d   = ISSUE;
          end
        end
      end
      RESEED: begin
        gen_pop_d = 1'b1;
        state_d   = ISSUE;
      end
      ISSUE: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        // A point arriving on the final count still beats the timeout.
        if (gen_valid) begin
          x_d          = gen_x;
          y_d          = gen_y;
          err_d        = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          x_d           = '0;
          y_d           = '0;
          err_d         = 1'b1;
          err_timeout_d = 1'b1;
          resp_valid_d  = 1'b1;
          state_d       = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          ptr_d        = id_q;
          served_d     = served_q + 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= PTR_RESET;
      id_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      err_q         <= 1'b0;
      resp_valid_q  <= 1'b0;
      gen_pop_q     <= 1'b0;
      gen_reseed_q  <= 1'b0;
      seed_q        <= '0;
      wait_cnt_q    <= '0;
      served_q      <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      x_q           <= x_d;
      y_q           <= y_d;
      err_q         <= err_d;
      resp_valid_q  <= resp_valid_d;
      gen_pop_q     <= gen_pop_d;
      gen_reseed_q  <= gen_reseed_d;
      seed_q        <= seed_d;
      wait_cnt_q    <= wait_cnt_d;
      served_q      <= served_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_id     = id_q;
  assign resp_x      = x_q;
  assign resp_y      = y_q;
  assign resp_err    = err_q;
  assign gen_pop     = gen_pop_q;
  assign gen_reseed  = gen_reseed_q;
  assign gen_seed    = seed_q;
  assign served_cnt  = served_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_disk_point_arbiter.sv
// tb/tb_disk_point_arbiter.sv - directed scoreboard bench for disk_point_arbiter
module tb_disk_point_arbiter;

  localparam int N = 4;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] x;
    logic [31:0] y;
    logic        err;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_reseed;
  logic [32*N-1:0] req_seed;
  logic [N-1:0]  req_ready;
  logic          resp_valid;
  logic          resp_ready;
  logic [1:0]    resp_id;
  logic [31:0]   resp_x;
  logic [31:0]   resp_y;
  logic          resp_err;
  logic          gen_pop;
  logic          gen_reseed;
  logic [31:0]   gen_seed;
  logic [31:0]   gen_x;
  logic [31:0]   gen_y;
  logic          gen_valid;
  logic [15:0]   served_cnt;
  logic          err_timeout;

  int   checks = 0;
  int   errors = 0;
  int   gen_lat = 0;
  int   cd = 0;
  exp_t sb[$];

  disk_point_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_reseed  (req_reseed),
    .req_seed    (req_seed),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_x      (resp_x),
    .resp_y      (resp_y),
    .resp_err    (resp_err),
    .gen_pop     (gen_pop),
    .gen_reseed  (gen_reseed),
    .gen_seed    (gen_seed),
    .gen_x       (gen_x),
    .gen_y       (gen_y),
    .gen_valid   (gen_valid),
    .served_cnt  (served_cnt),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator model: gen_valid pulses gen_lat cycles after gen_pop; gen_lat=0 never answers.
  initial begin : gen_model
    gen_valid = 1'b0;
    forever begin
      @(negedge clk);
      gen_valid = 1'b0;
      if (!rst_n) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd = cd - 1;
          if (cd == 0) gen_valid = 1'b1;
        end
        if (gen_pop && gen_lat > 0) cd = gen_lat;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 100) begin
      tick;
      cyc++;
    end
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    while (req_ready === '0 && cyc < 100) begin
      tick;
      cyc++;
    end
  endtask

  task automatic compare_resp(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(resp_valid), 32'h1);
      chk({tag, "_id"},    32'(resp_id),    32'(e.id));
      chk({tag, "_x"},     resp_x,          e.x);
      chk({tag, "_y"},     resp_y,          e.y);
      chk({tag, "_err"},   32'(resp_err),   32'(e.err));
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req_ready"},   32'(req_ready),   32'h0);
    chk({tag, "_resp_valid"},  32'(resp_valid),  32'h0);
    chk({tag, "_resp_id"},     32'(resp_id),     32'h0);
    chk({tag, "_resp_x"},      resp_x,           32'h0);
    chk({tag, "_resp_y"},      resp_y,           32'h0);
    chk({tag, "_resp_err"},    32'(resp_err),    32'h0);
    chk({tag, "_gen_pop"},     32'(gen_pop),     32'h0);
    chk({tag, "_gen_reseed"},  32'(gen_reseed),  32'h0);
    chk({tag, "_gen_seed"},    gen_seed,         32'h0);
    chk({tag, "_served"},      32'(served_cnt),  32'h0);
    chk({tag, "_err_timeout"}, 32'(err_timeout), 32'h0);
  endtask

  initial begin : stim
    int cyc;
    int hits;
    logic [31:0] hold_x;

    rst_n      = 1'b0;
    req_valid  = '0;
    req_reseed = '0;
    req_seed   = '0;
    resp_ready = 1'b1;
    gen_x      = '0;
    gen_y      = '0;
    repeat (3) tick;
    chk_idle("reset");
    rst_n = 1'b1;
    tick;

    // Single request, no reseed
    gen_lat   = 3;
    gen_x     = 32'h4000_0000;
    gen_y     = 32'hC000_0000;
    req_valid = 4'b0001;
    #1;
    chk("t1_grant", 32'(req_ready), 32'h1);
    sb.push_back('{id: 2'd0, x: 32'h4000_0000, y: 32'hC000_0000, err: 1'b0});
    tick;
    req_valid = '0;
    chk("t1_pop", 32'(gen_pop), 32'h1);
    chk("t1_no_reseed", 32'(gen_reseed), 32'h0);
    wait_resp(cyc);
    chk("t1_latency", 32'(cyc), 32'd4);
    compare_resp("t1");
    tick;
    chk("t1_valid_drop", 32'(resp_valid), 32'h0);
    chk("t1_served", 32'(served_cnt), 32'd1);

    // Reseed by requester 2
    gen_x      = 32'h1234_5678;
    gen_y      = 32'h8765_4321;
    req_valid  = 4'b0100;
    req_reseed = 4'b0100;
    req_seed[2*32 +: 32] = 32'd5;
    #1;
    chk("t2_grant", 32'(req_ready), 32'h4);
    sb.push_back('{id: 2'd2, x: 32'h1234_5678, y: 32'h8765_4321, err: 1'b0});
    tick;
    req_valid  = '0;
    req_reseed = '0;
    req_seed   = '0;
    chk("t2_reseed", 32'(gen_reseed), 32'h1);
    chk("t2_seed", gen_seed, 32'd5);
    chk("t2_no_pop_yet", 32'(gen_pop), 32'h0);
    tick;
    chk("t2_pop", 32'(gen_pop), 32'h1);
    chk("t2_reseed_drop", 32'(gen_reseed), 32'h0);
    chk("t2_seed_hold", gen_seed, 32'd5);
    wait_resp(cyc);
    compare_resp("t2");
    tick;

    // Round-robin fairness from a fresh pointer
    rst_n = 1'b0;
    tick;
    rst_n   = 1'b1;
    gen_lat = 1;
    tick;
    req_valid = 4'hF;
    #1;
    for (int i = 0; i < 8; i++) begin
      wait_grant(cyc);
      chk($sformatf("rr_grant%0d", i), 32'(req_ready), 32'h1 << (i % 4));
      gen_x = 32'h1000_0000 + 32'(i);
      gen_y = ~gen_x;
      sb.push_back('{id: 2'(i % 4), x: gen_x, y: gen_y, err: 1'b0});
      @(negedge clk);
      if (i == 7) req_valid = '0;
      #1;
      wait_resp(cyc);
      compare_resp($sformatf("rr%0d", i));
    end
    tick;
    chk("rr_served", 32'(served_cnt), 32'd8);

    // Backpressure: fields hold, no grant or pop until the handshake
    gen_lat    = 2;
    gen_x      = 32'hDEAD_BEEF;
    gen_y      = 32'h0BAD_F00D;
    resp_ready = 1'b0;
    req_valid  = 4'b0010;
    #1;
    chk("bp_grant", 32'(req_ready), 32'h2);
    sb.push_back('{id: 2'd1, x: 32'hDEAD_BEEF, y: 32'h0BAD_F00D, err: 1'b0});
    tick;
    req_valid = '0;
    chk("bp_pop", 32'(gen_pop), 32'h1);
    wait_resp(cyc);
    chk("bp_latency", 32'(cyc), 32'd3);
    hold_x    = 32'hDEAD_BEEF;
    req_valid = 4'hF;
    for (int k = 0; k < 10; k++) begin
      tick;
      chk($sformatf("bp_valid%0d", k), 32'(resp_valid), 32'h1);
      chk($sformatf("bp_x%0d", k), resp_x, hold_x);
      chk($sformatf("bp_id%0d", k), 32'(resp_id), 32'h1);
      chk($sformatf("bp_ready%0d", k), 32'(req_ready), 32'h0);
      chk($sformatf("bp_pop%0d", k), 32'(gen_pop), 32'h0);
    end
    compare_resp("bp");
    req_valid  = '0;
    resp_ready = 1'b1;
    tick;
    chk("bp_valid_drop", 32'(resp_valid), 32'h0);
    chk("bp_served", 32'(served_cnt), 32'd9);

    // Timeout with a silent generator
    gen_lat   = 0;
    gen_x     = 32'h7777_7777;
    gen_y     = 32'h5555_5555;
    req_valid = 4'b0001;
    #1;
    chk("to_grant", 32'(req_ready), 32'h1);
    sb.push_back('{id: 2'd0, x: 32'h0, y: 32'h0, err: 1'b1});
    tick;
    req_valid = '0;
    chk("to_pop", 32'(gen_pop), 32'h1);
    wait_resp(cyc);
    chk("to_latency", 32'(cyc), 32'd9);
    chk("to_sticky_set", 32'(err_timeout), 32'h1);
    compare_resp("to");
    tick;
    chk("to_served", 32'(served_cnt), 32'd10);

    // Good transaction afterwards keeps the sticky flag
    gen_lat   = 1;
    gen_x     = 32'h0ABC_0000;
    gen_y     = 32'hF000_0001;
    req_valid = 4'b1000;
    #1;
    chk("ok_grant", 32'(req_ready), 32'h8);
    sb.push_back('{id: 2'd3, x: 32'h0ABC_0000, y: 32'hF000_0001, err: 1'b0});
    tick;
    req_valid = '0;
    wait_resp(cyc);
    compare_resp("ok");
    tick;
    chk("ok_sticky", 32'(err_timeout), 32'h1);
    chk("ok_served", 32'(served_cnt), 32'd11);

    // Reset in the middle of WAIT discards the point
    gen_lat   = 0;
    req_valid = 4'b0100;
    #1;
    chk("rw_grant", 32'(req_ready), 32'h4);
    tick;
    req_valid = '0;
    chk("rw_pop", 32'(gen_pop), 32'h1);
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    chk_idle("rw_reset");
    tick;
    tick;
    rst_n = 1'b1;
    hits  = 0;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (resp_valid === 1'b1) hits++;
    end
    chk("rw_no_resp", 32'(hits), 32'h0);
    gen_lat   = 1;
    gen_x     = 32'h2468_ACE0;
    gen_y     = 32'h1357_9BDF;
    req_valid = 4'hF;
    #1;
    chk("rw_first_grant", 32'(req_ready), 32'h1);
    sb.push_back('{id: 2'd0, x: 32'h2468_ACE0, y: 32'h1357_9BDF, err: 1'b0});
    tick;
    req_valid = '0;
    wait_resp(cyc);
    compare_resp("rw");
    tick;
    chk("rw_served", 32'(served_cnt), 32'd1);
    chk("rw_sticky_clear", 32'(err_timeout), 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
